// File: rtl/blend_pkg.sv
// Shared types and default widths for the alpha-blend multiplier scheduler.
package blend_pkg;

    localparam int PIX_W_D  = 16;
    localparam int PROD_W_D = 34;
    localparam int OUT_W_D  = 36;
    localparam int CNT_W_D  = 18;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MUL_A = 2'd1;
    localparam logic [1:0] ST_MUL_B = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        MUL_A = ST_MUL_A,
        MUL_B = ST_MUL_B,
        OUT   = ST_OUT
    } state_t;

endpackage

// File: rtl/counter_mult.sv
// Combinational unsigned multiplier: partial products folded through a chain
// of 3:2 carry-save compressors, one carry-propagate add at the end.
module counter_mult #(
    parameter int A_W = 16,
    parameter int P_W = 34
) (
    input  logic [A_W-1:0] a,
    input  logic [A_W-1:0] b,
    output logic [P_W-1:0] p
);

    logic [P_W-1:0] s, c, pp, t, nc;

    // Carry-save reduction of the A_W partial products, then final add.
    always_comb begin
        s  = '0;
        c  = '0;
        pp = '0;
        t  = '0;
        nc = '0;
        for (int i = 0; i < A_W; i++) begin
            pp = b[i] ? (P_W'(a) << i) : '0;
            t  = s ^ c ^ pp;
            nc = ((s & c) | (s & pp) | (c & pp)) << 1;
            s  = t;
            c  = nc;
        end
        p = s + c;
    end

endmodule

// File: rtl/blend_mult_scheduler.sv
// Alpha blend out = (coef_a*pix_a + coef_b*pix_b) >> SHIFT, both products
// computed on one shared multiplier over two cycles (MUL_A, MUL_B).
module blend_mult_scheduler
    import blend_pkg::*;
#(
    parameter int PIX_W  = PIX_W_D,
    parameter int PROD_W = PROD_W_D,
    parameter int OUT_W  = OUT_W_D,
    parameter int SHIFT  = 0,
    parameter int CNT_W  = CNT_W_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PIX_W-1:0] cfg_coef_a,
    input  logic [PIX_W-1:0] cfg_coef_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] pix_a,
    input  logic [PIX_W-1:0] pix_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_pix,
    output logic             out_last,
    output logic [CNT_W-1:0] pix_count,
    output logic             frame_done
);

    state_t            state, state_nxt;
    logic              accept, out_hs;
    logic [PIX_W-1:0]  coef_a_sh, coef_b_sh;
    logic [PIX_W-1:0]  coef_a_r, coef_b_r, pix_a_r, pix_b_r;
    logic              last_r;
    logic [PIX_W-1:0]  op_x, op_y;
    logic [PROD_W-1:0] prod;
    logic [OUT_W-1:0]  acc;

    assign accept    = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;
    assign out_pix   = out_valid ? (acc >> SHIFT) : '0;
    assign out_last  = out_valid & last_r;

    counter_mult #(.A_W(PIX_W), .P_W(PROD_W)) u_mult (
        .a (op_x),
        .b (op_y),
        .p (prod)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, handshake outputs and multiplier operand mux.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        op_x      = '0;
        op_y      = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = MUL_A;
            end
            MUL_A: begin
                op_x      = coef_a_r;
                op_y      = pix_a_r;
                state_nxt = MUL_B;
            end
            MUL_B: begin
                op_x      = coef_b_r;
                op_y      = pix_b_r;
                state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_nxt = in_valid ? MUL_A : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Coefficient shadows; writable any cycle, sampled only at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            coef_a_sh <= '0;
            coef_b_sh <= '0;
        end else if (cfg_we) begin
            coef_a_sh <= cfg_coef_a;
            coef_b_sh <= cfg_coef_b;
        end
    end

    // Per-pixel operand capture; a same-cycle cfg write is not seen here.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_a_r  <= '0;
            pix_b_r  <= '0;
            coef_a_r <= '0;
            coef_b_r <= '0;
            last_r   <= 1'b0;
        end else if (accept) begin
            pix_a_r  <= pix_a;
            pix_b_r  <= pix_b;
            coef_a_r <= coef_a_sh;
            coef_b_r <= coef_b_sh;
            last_r   <= in_last;
        end
    end

    // Accumulator: first product loads, second product adds.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else begin
            case (state)
                MUL_A:   acc <= OUT_W'(prod);
                MUL_B:   acc <= acc + OUT_W'(prod);
                default: acc <= acc;
            endcase
        end
    end

    // Frame pixel counter and end-of-frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_count  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (out_hs) begin
                if (last_r) begin
                    pix_count  <= '0;
                    frame_done <= 1'b1;
                end else begin
                    pix_count <= pix_count + 1'b1;
                end
            end
        end
    end

endmodule
